// File: rtl/mips_pkg.sv
// Shared MIPS decode constants, ALU opcodes and the ID/EX control bundle.
// Consumers: alu_ctrl_dec and id_ex_stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  localparam logic [3:0] ALU_ADD    = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0111;
  localparam logic [3:0] ALU_SUB_EQ = 4'b0110;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       illegal;
    logic [3:0] alu_control;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } ex_ctrl_t;

  // Source indices are zeroed in a bubble so it can never match a forwarding producer.
  localparam ex_ctrl_t EX_BUBBLE = '{
    valid: 1'b0, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
    mem_to_reg: 1'b0, alu_src: 1'b0, illegal: 1'b0, alu_control: ALU_ADD,
    dest: 5'd0, rs: 5'd0, rt: 5'd0
  };

  // EX/MEM wins over MEM/WB; register 0 is never forwarded.
  function automatic logic [31:0] fwd_operand(
    input logic [4:0]  idx,
    input logic [31:0] reg_val,
    input logic        xm_we,
    input logic [4:0]  xm_dest,
    input logic [31:0] xm_res,
    input logic        mw_we,
    input logic [4:0]  mw_dest,
    input logic [31:0] mw_res
  );
    if (xm_we && xm_dest != 5'd0 && xm_dest == idx) return xm_res;
    if (mw_we && mw_dest != 5'd0 && mw_dest == idx) return mw_res;
    return reg_val;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational Opcode/Funct to ALU opcode decode; flags unsupported encodings.
module alu_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal_op
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal_op  = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_ADDU: alu_control = ALU_ADD;
          FN_SLT:          alu_control = ALU_SLT;
          default:         illegal_op  = 1'b1;
        endcase
      end
      OP_LW, OP_SW, OP_ADDI, OP_ADDIU: alu_control = ALU_ADD;
      OP_SLTI:                         alu_control = ALU_SLT;
      OP_BEQ:                          alu_control = ALU_SUB_EQ;
      default:                         illegal_op  = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU decode, operand forwarding and load-use stall.
// Define ID_EX_FORWARDING_EN to enable EX/MEM and MEM/WB forwarding.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic        IdValid,
  input  logic [5:0]  Opcode,
  input  logic [5:0]  Funct,
  input  logic [31:0] RsData,
  input  logic [31:0] RtData,
  input  logic [31:0] Imm,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemWriteIn,
  input  logic        MemToRegIn,
  input  logic        RegDstIn,
  input  logic        ALUSrcIn,
  input  logic        Flush,
  input  logic        StallIn,
  input  logic        ExMemRegWrite,
  input  logic [4:0]  ExMemDest,
  input  logic [31:0] ExMemResult,
  input  logic        MemWbRegWrite,
  input  logic [4:0]  MemWbDest,
  input  logic [31:0] MemWbResult,
  output logic [3:0]  ALUControl,
  output logic [31:0] DataIn0,
  output logic [31:0] DataIn1,
  output logic [31:0] StoreData,
  output logic [4:0]  DestReg,
  output logic        ExValid,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        IllegalOp,
  output logic        StallOut
);

  // ExValid marks a real instruction in EX; StallOut asks PC and IF/ID to hold this cycle.
  logic [3:0]  id_alu_control;
  logic        id_illegal;
  ex_ctrl_t    ctrl_d, ctrl_q;
  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic        ex_hit, hazard;
  logic [31:0] opnd_a, opnd_b;

  alu_ctrl_dec u_dec (
    .opcode      (Opcode),
    .funct       (Funct),
    .alu_control (id_alu_control),
    .illegal_op  (id_illegal)
  );

  always_comb begin
    ctrl_d             = EX_BUBBLE;
    ctrl_d.valid       = IdValid;
    ctrl_d.reg_write   = RegWriteIn & ~id_illegal;
    ctrl_d.mem_read    = MemReadIn  & ~id_illegal;
    ctrl_d.mem_write   = MemWriteIn & ~id_illegal;
    ctrl_d.mem_to_reg  = MemToRegIn;
    ctrl_d.alu_src     = ALUSrcIn;
    ctrl_d.illegal     = id_illegal;
    ctrl_d.alu_control = id_alu_control;
    ctrl_d.dest        = RegDstIn ? Rd : Rt;
    ctrl_d.rs          = Rs;
    ctrl_d.rt          = Rt;
  end

  assign ex_hit = (ctrl_q.dest != 5'd0) && (ctrl_q.dest == Rs || ctrl_q.dest == Rt);

`ifdef ID_EX_FORWARDING_EN
  assign hazard = IdValid & ctrl_q.valid & ctrl_q.mem_read & ex_hit;
  assign opnd_a = fwd_operand(ctrl_q.rs, rs_data_q, ExMemRegWrite, ExMemDest, ExMemResult,
                              MemWbRegWrite, MemWbDest, MemWbResult);
  assign opnd_b = fwd_operand(ctrl_q.rt, rt_data_q, ExMemRegWrite, ExMemDest, ExMemResult,
                              MemWbRegWrite, MemWbDest, MemWbResult);
`else
  // Without forwarding, any in-flight writer still ahead of the register file must drain.
  logic xm_hit;
  logic unused_fwd_inputs;
  assign xm_hit = ExMemRegWrite && (ExMemDest != 5'd0) && (ExMemDest == Rs || ExMemDest == Rt);
  assign hazard = IdValid & ((ctrl_q.valid & ctrl_q.reg_write & ex_hit) | xm_hit);
  assign opnd_a = rs_data_q;
  assign opnd_b = rt_data_q;
  assign unused_fwd_inputs = ^{ExMemResult, MemWbRegWrite, MemWbDest, MemWbResult};
`endif

  always_ff @(posedge Clk) begin
    if (Reset || Flush || (!StallIn && hazard)) begin
      ctrl_q    <= EX_BUBBLE;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else if (!StallIn) begin
      ctrl_q    <= ctrl_d;
      rs_data_q <= RsData;
      rt_data_q <= RtData;
      imm_q     <= Imm;
    end
  end

  assign StallOut   = (hazard | StallIn) & ~Flush;
  assign ALUControl = ctrl_q.alu_control;
  assign DataIn0    = opnd_a;
  assign DataIn1    = ctrl_q.alu_src ? imm_q : opnd_b;
  assign StoreData  = opnd_b;
  assign DestReg    = ctrl_q.dest;
  assign ExValid    = ctrl_q.valid;
  assign RegWrite   = ctrl_q.reg_write;
  assign MemRead    = ctrl_q.mem_read;
  assign MemWrite   = ctrl_q.mem_write;
  assign MemToReg   = ctrl_q.mem_to_reg;
  assign IllegalOp  = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a slot-level reference model.
// Follows ID_EX_FORWARDING_EN in the same way as the design.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk, reset, id_valid, flush, stall_in;
  logic [5:0]  opcode, funct;
  logic [31:0] rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd;
  logic        reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_dst_in, alu_src_in;
  logic        xm_we, mw_we;
  logic [4:0]  xm_dest, mw_dest;
  logic [31:0] xm_res, mw_res;
  logic [3:0]  alu_control;
  logic [31:0] data_in0, data_in1, store_data;
  logic [4:0]  dest_reg;
  logic        ex_valid, reg_write, mem_read, mem_write, mem_to_reg, illegal_op, stall_out;

  int tests_run = 0;
  int failed = 0;

  id_ex_stage dut (
    .Clk(clk), .Reset(reset), .IdValid(id_valid), .Opcode(opcode), .Funct(funct),
    .RsData(rs_data), .RtData(rt_data), .Imm(imm), .Rs(rs), .Rt(rt), .Rd(rd),
    .RegWriteIn(reg_write_in), .MemReadIn(mem_read_in), .MemWriteIn(mem_write_in),
    .MemToRegIn(mem_to_reg_in), .RegDstIn(reg_dst_in), .ALUSrcIn(alu_src_in),
    .Flush(flush), .StallIn(stall_in),
    .ExMemRegWrite(xm_we), .ExMemDest(xm_dest), .ExMemResult(xm_res),
    .MemWbRegWrite(mw_we), .MemWbDest(mw_dest), .MemWbResult(mw_res),
    .ALUControl(alu_control), .DataIn0(data_in0), .DataIn1(data_in1),
    .StoreData(store_data), .DestReg(dest_reg), .ExValid(ex_valid),
    .RegWrite(reg_write), .MemRead(mem_read), .MemWrite(mem_write),
    .MemToReg(mem_to_reg), .IllegalOp(illegal_op), .StallOut(stall_out)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // ---------------- reference model: contents of the EX slot ----------------
  typedef struct {
    bit          valid, rw, mr, mw, m2r, src, ill;
    logic [3:0]  aluc;
    logic [31:0] a, b, imm;
    logic [4:0]  rs, rt, dest;
  } slot_t;

  slot_t m;

  function automatic slot_t bubble();
    slot_t s;
    s = '{valid: 0, rw: 0, mr: 0, mw: 0, m2r: 0, src: 0, ill: 0, aluc: 4'd2,
          a: 0, b: 0, imm: 0, rs: 0, rt: 0, dest: 0};
    return s;
  endfunction

  // Returns {illegal, alu opcode} from the instruction-set table.
  function automatic logic [4:0] decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'd0) begin
      if (fn == 6'd32 || fn == 6'd33) return {1'b0, 4'd2};
      if (fn == 6'd42) return {1'b0, 4'd7};
      return {1'b1, 4'd2};
    end
    if (op == 6'd35 || op == 6'd43 || op == 6'd8 || op == 6'd9) return {1'b0, 4'd2};
    if (op == 6'd10) return {1'b0, 4'd7};
    if (op == 6'd4) return {1'b0, 4'd6};
    return {1'b1, 4'd2};
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return r != 5'd0 && (r == rs || r == rt);
  endfunction

  function automatic bit model_hazard();
    if (!id_valid) return 0;
    if (FWD) return m.valid && m.mr && reads(m.dest);
    return (m.valid && m.rw && reads(m.dest)) || (xm_we && reads(xm_dest));
  endfunction

  // Producers listed youngest first; the first writer of the register supplies it.
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regv);
    logic        we [2];
    logic [4:0]  dst [2];
    logic [31:0] val [2];
    if (!FWD) return regv;
    we[0] = xm_we; dst[0] = xm_dest; val[0] = xm_res;
    we[1] = mw_we; dst[1] = mw_dest; val[1] = mw_res;
    for (int k = 0; k < 2; k++)
      if (we[k] && dst[k] != 0 && dst[k] == idx) return val[k];
    return regv;
  endfunction

  task automatic model_update();
    logic [4:0] d;
    bit haz;
    haz = model_hazard();
    if (reset || flush) m = bubble();
    else if (stall_in) m = m;
    else if (haz) m = bubble();
    else begin
      d = decode(opcode, funct);
      m.valid = id_valid;   m.ill = d[4];        m.aluc = d[3:0];
      m.rw = reg_write_in && !d[4];
      m.mr = mem_read_in && !d[4];
      m.mw = mem_write_in && !d[4];
      m.m2r = mem_to_reg_in; m.src = alu_src_in;
      m.a = rs_data; m.b = rt_data; m.imm = imm;
      m.rs = rs; m.rt = rt; m.dest = reg_dst_in ? rd : rt;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [31:0] ea, eb;
    ea = operand(m.rs, m.a);
    eb = operand(m.rt, m.b);
    chk("m_aluc", alu_control, m.aluc);
    chk("m_din0", data_in0, m.valid || m.a != 0 ? ea : 32'd0);
    chk("m_din1", data_in1, m.src ? m.imm : eb);
    chk("m_store", store_data, eb);
    chk("m_dest", dest_reg, m.dest);
    chk("m_ctrl", {ex_valid, reg_write, mem_read, mem_write, mem_to_reg, illegal_op},
        {m.valid, m.rw, m.mr, m.mw, m.m2r, m.ill});
    chk("m_stall", stall_out, (model_hazard() || stall_in) && !flush);
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic id_idle();
    id_valid = 0; opcode = 0; funct = 0; rs = 0; rt = 0; rd = 0;
    rs_data = 0; rt_data = 0; imm = 0;
    reg_write_in = 0; mem_read_in = 0; mem_write_in = 0;
    mem_to_reg_in = 0; reg_dst_in = 0; alu_src_in = 0;
  endtask

  task automatic fwd_clear();
    xm_we = 0; xm_dest = 0; xm_res = 0; mw_we = 0; mw_dest = 0; mw_res = 0;
  endtask

  task automatic set_r(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t,
                       input logic [4:0] d, input logic [31:0] sd, input logic [31:0] td);
    id_idle();
    id_valid = 1; opcode = 6'd0; funct = fn; rs = s; rt = t; rd = d;
    rs_data = sd; rt_data = td; reg_write_in = 1; reg_dst_in = 1;
  endtask

  task automatic set_lw(input logic [4:0] base, input logic [4:0] t);
    id_idle();
    id_valid = 1; opcode = 6'd35; rs = base; rt = t; imm = 32'd8;
    reg_write_in = 1; mem_read_in = 1; mem_to_reg_in = 1; alu_src_in = 1;
  endtask

  task automatic randomize_inputs();
    logic [5:0] ops [8];
    logic [5:0] fns [4];
    ops = '{6'd0, 6'd35, 6'd43, 6'd8, 6'd9, 6'd10, 6'd4, 6'd63};
    fns = '{6'd32, 6'd33, 6'd42, 6'd0};
    fns[3] = 6'($urandom);
    reset    = ($urandom_range(0, 39) == 0);
    flush    = ($urandom_range(0, 9) == 0);
    stall_in = ($urandom_range(0, 7) == 0);
    id_valid = ($urandom_range(0, 7) != 0);
    opcode = ops[$urandom_range(0, 7)];
    funct  = fns[$urandom_range(0, 3)];
    rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
    rs_data = $urandom; rt_data = $urandom; imm = $urandom;
    {reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_dst_in, alu_src_in} = 6'($urandom);
    xm_we = 1'($urandom); xm_dest = 5'($urandom_range(0, 3)); xm_res = $urandom;
    mw_we = 1'($urandom); mw_dest = 5'($urandom_range(0, 3)); mw_res = $urandom;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    reset = 1; flush = 0; stall_in = 0;
    id_idle(); fwd_clear();
    m = bubble();
    repeat (2) begin
      @(posedge clk); model_update();
    end
    @(negedge clk); #1;
    chk("rst_aluc", alu_control, 4'b0010);
    chk("rst_outs", {data_in0, data_in1, store_data}, 96'd0);
    chk("rst_ctrl", {dest_reg, ex_valid, reg_write, mem_read, mem_write, mem_to_reg, illegal_op, stall_out}, 12'd0);
    reset = 0;

    set_r(6'd32, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    id_idle(); #1;
    chk("add_aluc", alu_control, 4'b0010);
    chk("add_din0", data_in0, 32'd5);
    chk("add_din1", data_in1, 32'd7);
    chk("add_dest", dest_reg, 5'd3);
    chk("add_rw", reg_write, 1'b1);

    set_r(6'd34 - 6'd2, 5'd4, 5'd2, 5'd7, 32'h44, 32'h22);
    step();
    id_idle();
    xm_we = 1; xm_dest = 4; xm_res = 32'h99; mw_we = 1; mw_dest = 4; mw_res = 32'h11; #1;
    chk("fwd_exmem", data_in0, FWD ? 32'h99 : 32'h44);
    xm_we = 0; #1;
    chk("fwd_memwb", data_in0, FWD ? 32'h11 : 32'h44);
    xm_we = 1; xm_dest = 0; mw_dest = 0; #1;
    chk("fwd_zero", data_in0, 32'h44);
    fwd_clear();

    set_lw(5'd1, 5'd5);
    step();
    set_r(6'd42, 5'd5, 5'd1, 5'd6, 32'd0, 32'd3); #1;
    chk("lu_stall", stall_out, 1'b1);
    step();
    chk("lu_bubble", ex_valid, 1'b0);
    xm_we = 1; xm_dest = 5; xm_res = 32'h55; #1;
    chk("lu_stall2", stall_out, !FWD);
`ifndef ID_EX_FORWARDING_EN
    step();
    xm_we = 0; rs_data = 32'h55;
`endif
    step();
    xm_we = 0; mw_we = 1; mw_dest = 5; mw_res = 32'h55; #1;
    chk("lu_aluc", alu_control, 4'b0111);
    chk("lu_din0", data_in0, 32'h55);
    chk("lu_valid", ex_valid, 1'b1);
    fwd_clear();

    set_lw(5'd1, 5'd5);
    step();
    set_r(6'd42, 5'd5, 5'd1, 5'd6, 32'd0, 32'd3);
    flush = 1; #1;
    chk("fl_stall", stall_out, 1'b0);
    step();
    chk("fl_bubble", ex_valid, 1'b0);
    flush = 0;

    set_r(6'd32, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7);
    step();
    id_idle(); id_valid = 1; opcode = 6'd63; reg_write_in = 1; mem_write_in = 1; mem_read_in = 1;
    stall_in = 1; #1;
    chk("si_stall", stall_out, 1'b1);
    step();
    chk("si_hold", {ex_valid, alu_control, dest_reg}, {1'b1, 4'd2, 5'd3});
    chk("si_data", {data_in0, data_in1}, {32'd5, 32'd7});
    stall_in = 0;
    step();
    chk("ill_flag", illegal_op, 1'b1);
    chk("ill_ctrl", {reg_write, mem_write, mem_read}, 3'b000);

    id_idle(); id_valid = 1; opcode = 6'd4; rs = 1; rt = 2;
    step();
    chk("beq_aluc", alu_control, 4'b0110);

    set_lw(5'd1, 5'd5);
    step();
    set_r(6'd42, 5'd5, 5'd1, 5'd6, 32'd0, 32'd3); #1;
    chk("rs_stall", stall_out, 1'b1);
    reset = 1;
    step();
    reset = 0; #1;
    chk("rs_bubble", ex_valid, 1'b0);
    chk("rs_nostall", stall_out, 1'b0);

    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
